// File: rtl/if_pcgen_pkg.sv
// Shared definitions for the IF1 PC generator.
// - pcgen_state_e : FSM state encoding (boot / run / drain)
// - bus_*_bit/lsb : field offsets inside the IF1->IF2 bus
//   {valid, epoch, slot_mask[FETCH_W-1:0], pc[PC_WD-1:0]}
package if_pcgen_pkg;

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } pcgen_state_e;

  // pc occupies the low PC_WD bits; slot_mask sits directly above it.
  function automatic int unsigned bus_mask_lsb(int unsigned pc_wd);
    return pc_wd;
  endfunction

  function automatic int unsigned bus_epoch_bit(int unsigned pc_wd, int unsigned fetch_w);
    return pc_wd + fetch_w;
  endfunction

  function automatic int unsigned bus_valid_bit(int unsigned pc_wd, int unsigned fetch_w);
    return pc_wd + fetch_w + 1;
  endfunction

endpackage

// File: rtl/if_pcgen_outst_cnt.sv
// Outstanding-request counter for the IF1 PC generator.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   inc_i         : a request fired this cycle
//   dec_i         : a response returned this cycle (ignored when count is 0)
//   snap_i        : redirect; everything in flight becomes old-epoch
//   cnt_o         : requests currently in flight
//   old_cnt_o     : in-flight requests that belong to a superseded epoch
module if_pcgen_outst_cnt #(
  parameter int unsigned MAX_OUTST = 2,
  parameter int unsigned CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] old_cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] old_q, old_d;
  logic             dec_eff;

  // A response with nothing in flight is dropped rather than wrapping.
  assign dec_eff = dec_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({inc_i, dec_eff})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Responses arrive in order, so old-epoch ones are retired first.
  always_comb begin
    old_d = old_q;
    if (snap_i) begin
      old_d = cnt_q - CNT_W'(dec_eff);
    end else if (dec_eff && (old_q != '0)) begin
      old_d = old_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      old_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      old_q <= old_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign old_cnt_o = old_q;

endmodule

// File: rtl/if_pcgen.sv
// IF1 PC generator: issues fetch-block requests to instruction memory over a
// valid/ready handshake, limits requests in flight, and tags each block with
// an epoch bit that flips on every flush/branch redirect.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush_i, new_pc_i   : backend redirect (highest priority) and its target
//   br_bus_i            : {br_e, br_addr} branch redirect
//   stall_i             : IF2 cannot take a new request
//   req_valid_o/ready_i : memory request handshake, req_addr_o block-aligned
//   resp_valid_i        : one memory response returned (any epoch)
//   if12if2_bus_o       : {valid, epoch, slot_mask, pc}, one cycle after fire
//   redirect_misalign_o : only when IF_PCGEN_ALIGN_CHK_EN is defined
// Build option IF_PCGEN_ALIGN_CHK_EN: keep misaligned redirect targets, flag
// them and block fetch until the next redirect. Otherwise bits [1:0] of the
// target are cleared on load.
module if_pcgen
  import if_pcgen_pkg::*;
#(
  parameter int unsigned       PC_WD      = 32,
  parameter logic [PC_WD-1:0]  RESET_PC   = 32'h8000_0000,
  parameter int unsigned       FETCH_W    = 2,
  parameter int unsigned       MAX_OUTST  = 2,
  parameter int unsigned       IF12IF2_WD = PC_WD + FETCH_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [PC_WD-1:0]      new_pc_i,
  input  logic [PC_WD:0]        br_bus_i,
  input  logic                  stall_i,
  output logic                  req_valid_o,
  input  logic                  req_ready_i,
  output logic [PC_WD-1:0]      req_addr_o,
  input  logic                  resp_valid_i,
  output logic [IF12IF2_WD-1:0] if12if2_bus_o
`ifdef IF_PCGEN_ALIGN_CHK_EN
  ,
  output logic                  redirect_misalign_o
`endif
);

  localparam int unsigned      OffW       = $clog2(FETCH_W * 4);
  localparam int unsigned      CntW       = $clog2(MAX_OUTST + 1);
  localparam logic [PC_WD-1:0] FetchBytes = PC_WD'(FETCH_W * 4);
  localparam logic [PC_WD-1:0] OffMask    = PC_WD'(FETCH_W * 4 - 1);
  localparam int unsigned      MaskLsb    = bus_mask_lsb(PC_WD);
  localparam int unsigned      EpochBit   = bus_epoch_bit(PC_WD, FETCH_W);
  localparam int unsigned      ValidBit   = bus_valid_bit(PC_WD, FETCH_W);

  pcgen_state_e       state_q, state_d;
  logic [PC_WD-1:0]   pc_q, pc_d;
  logic               epoch_q, epoch_d;
  logic               bus_v_q;
  logic               bus_epoch_q;
  logic [FETCH_W-1:0] bus_mask_q, slot_mask;
  logic [PC_WD-1:0]   bus_pc_q;

  logic               br_e;
  logic [PC_WD-1:0]   br_addr;
  logic               redirect;
  logic [PC_WD-1:0]   target_raw, target;
  logic [PC_WD-1:0]   blk_addr;
  logic [OffW-1:0]    slot_idx;
  logic               fetch_blocked;
  logic               fire;
  logic [CntW-1:0]    outst, old_cnt;

  assign br_e       = br_bus_i[PC_WD];
  assign br_addr    = br_bus_i[PC_WD-1:0];
  assign redirect   = flush_i | br_e;
  assign target_raw = flush_i ? new_pc_i : br_addr;

`ifdef IF_PCGEN_ALIGN_CHK_EN
  logic misalign_q, block_q;
  logic tgt_misaligned;

  assign tgt_misaligned = |target_raw[1:0];
  assign target         = target_raw;
  assign fetch_blocked  = block_q;

  // A misaligned target stays parked until some later redirect replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
      block_q    <= 1'b0;
    end else begin
      misalign_q <= redirect & tgt_misaligned;
      if (redirect) begin
        block_q <= tgt_misaligned;
      end
    end
  end

  assign redirect_misalign_o = misalign_q;
`else
  assign target        = target_raw & ~PC_WD'(3);
  assign fetch_blocked = 1'b0;
`endif

  assign blk_addr    = pc_q & ~OffMask;
  assign req_addr_o  = blk_addr;
  assign req_valid_o = (state_q != StBoot) & ~stall_i & (outst < CntW'(MAX_OUTST)) &
                       ~redirect & ~fetch_blocked;
  assign fire        = req_valid_o & req_ready_i;

  // Slots before the instruction pc points at are not part of this fetch.
  assign slot_idx = pc_q[OffW-1:0] >> 2;
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      slot_mask[i] = (OffW'(i) >= slot_idx);
    end
  end

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect) begin
      pc_d    = target;
      epoch_d = ~epoch_q;
    end else if (fire) begin
      pc_d = blk_addr + FetchBytes;
    end
  end

  // DRAIN only tracks retirement of old-epoch responses; it never gates issue.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      StDrain: if (old_cnt == '0) state_d = StRun;
      default: state_d = StBoot;
    endcase
    if (redirect) begin
      state_d = (outst != '0) ? StDrain : StRun;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      epoch_q     <= 1'b0;
      bus_v_q     <= 1'b0;
      bus_epoch_q <= 1'b0;
      bus_mask_q  <= '0;
      bus_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      bus_v_q <= fire;
      if (fire) begin
        bus_epoch_q <= epoch_q;
        bus_mask_q  <= slot_mask;
        bus_pc_q    <= pc_q;
      end
    end
  end

  // A flush in the presentation cycle kills the block on its way to IF2.
  always_comb begin
    if12if2_bus_o                         = '0;
    if12if2_bus_o[ValidBit]               = bus_v_q & ~flush_i;
    if12if2_bus_o[EpochBit]               = bus_epoch_q;
    if12if2_bus_o[MaskLsb +: FETCH_W]     = bus_mask_q;
    if12if2_bus_o[PC_WD-1:0]              = bus_pc_q;
  end

  if_pcgen_outst_cnt #(
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CntW)
  ) u_outst_cnt (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (fire),
    .dec_i     (resp_valid_i),
    .snap_i    (redirect),
    .cnt_o     (outst),
    .old_cnt_o (old_cnt)
  );

endmodule

// File: tb/tb_if_pcgen.sv
// Bench for if_pcgen (PC_WD=32, FETCH_W=2, MAX_OUTST=2): directed scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_if_pcgen;
  localparam int unsigned PC_WD     = 32;
  localparam int unsigned FETCH_W   = 2;
  localparam int unsigned MAX_OUTST = 2;
  localparam int unsigned BUS_WD    = PC_WD + FETCH_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [PC_WD-1:0]  new_pc = '0;
  logic [PC_WD:0]    br_bus = '0;
  logic              stall = 1'b0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [PC_WD-1:0]  req_addr;
  logic              resp_valid = 1'b0;
  logic [BUS_WD-1:0] bus;
`ifdef IF_PCGEN_ALIGN_CHK_EN
  logic              misalign;
`endif

  always #5 clk = ~clk;

  if_pcgen #(
    .PC_WD     (PC_WD),
    .RESET_PC  (32'h8000_0000),
    .FETCH_W   (FETCH_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush),
    .new_pc_i            (new_pc),
    .br_bus_i            (br_bus),
    .stall_i             (stall),
    .req_valid_o         (req_valid),
    .req_ready_i         (req_ready),
    .req_addr_o          (req_addr),
    .resp_valid_i        (resp_valid),
    .if12if2_bus_o       (bus)
`ifdef IF_PCGEN_ALIGN_CHK_EN
    ,
    .redirect_misalign_o (misalign)
`endif
  );

  wire               bus_v     = bus[PC_WD+FETCH_W+1];
  wire               bus_epoch = bus[PC_WD+FETCH_W];
  wire [FETCH_W-1:0] bus_mask  = bus[PC_WD+FETCH_W-1:PC_WD];
  wire [PC_WD-1:0]   bus_pc    = bus[PC_WD-1:0];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0]        m_pc;
  bit                 m_epoch, m_boot, m_block, m_mis;
  int                 m_outst;
  bit                 m_bv, m_be;
  logic [FETCH_W-1:0] m_bm;
  logic [31:0]        m_bp;

  function automatic bit exp_req_valid();
    return !m_boot && !stall && (m_outst < MAX_OUTST) && !flush && !br_bus[PC_WD] && !m_block;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_pc & ~32'(FETCH_W * 4 - 1);
  endfunction

  function automatic logic [FETCH_W-1:0] exp_mask(logic [31:0] pc);
    int slot;
    logic [FETCH_W-1:0] m;
    slot = int'((pc >> 2) % FETCH_W);
    for (int i = 0; i < FETCH_W; i++) m[i] = (i >= slot);
    return m;
  endfunction

  task automatic model_reset();
    m_pc = 32'h8000_0000; m_epoch = 0; m_boot = 1; m_block = 0; m_mis = 0;
    m_outst = 0; m_bv = 0; m_be = 0; m_bm = '0; m_bp = '0;
  endtask

  // Advance model and DUT across one rising edge using the currently driven inputs.
  task automatic tick();
    bit fire, redir;
    logic [31:0] tgt;
    fire  = exp_req_valid() && req_ready;
    redir = flush || br_bus[PC_WD];
    tgt   = flush ? new_pc : br_bus[PC_WD-1:0];
    @(posedge clk);
    m_bv = fire;
    if (fire) begin m_be = m_epoch; m_bm = exp_mask(m_pc); m_bp = m_pc; end
    m_mis = 0;
    if (redir) begin
`ifdef IF_PCGEN_ALIGN_CHK_EN
      m_pc = tgt; m_block = (tgt[1:0] != 0); m_mis = m_block;
`else
      m_pc = tgt & ~32'd3;
`endif
      m_epoch = !m_epoch;
    end else if (fire) begin
      m_pc = exp_addr() + 32'(FETCH_W * 4);
    end
    if (resp_valid && m_outst > 0) m_outst--;
    if (fire) m_outst++;
    m_boot = 0;
  endtask

  task automatic drive(bit f, logic [31:0] npc, bit be, logic [31:0] ba, bit st, bit rdy, bit rsp);
    @(negedge clk);
    flush = f; new_pc = npc; br_bus = {be, ba}; stall = st; req_ready = rdy; resp_valid = rsp;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1;
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    n_cmp++; if (bus !== '0) begin n_err++; $display("FAIL reset_bus got %h want 0", bus); end
`ifdef IF_PCGEN_ALIGN_CHK_EN
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign got %b want 0", misalign); end
`endif
    rst = 0;
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL boot_req_valid got %b want 0", req_valid); end
    tick();
  endtask

  task automatic test_fetch_stream();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %b want 1", k, req_valid); end
      n_cmp++;
      if (req_addr !== 32'h8000_0000 + 32'(8 * k)) begin
        n_err++; $display("FAIL stream_addr[%0d] got %h want %h", k, req_addr, 32'h8000_0000 + 32'(8 * k));
      end
      if (k == 0) begin
        n_cmp++; if (bus_v !== 1'b0) begin n_err++; $display("FAIL stream_bus_v0 got %b want 0", bus_v); end
      end else begin
        n_cmp++;
        if ({bus_v, bus_epoch, bus_mask, bus_pc} !== {1'b1, 1'b0, 2'b11, 32'h8000_0000 + 32'(8 * (k - 1))}) begin
          n_err++; $display("FAIL stream_bus[%0d] got %h want v=1 e=0 m=11 pc=%h", k, bus,
                            32'h8000_0000 + 32'(8 * (k - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_outst_limit();
    int fires;
    drain();
    fires = 0;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      if (req_valid) fires++;
      tick();
    end
    n_cmp++; if (fires !== 2) begin n_err++; $display("FAIL outst_fires got %0d want 2", fires); end
    drive(0, 0, 0, 0, 0, 1, 1);
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL outst_full got %b want 0", req_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL outst_after_resp got %b want 1", req_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL outst_refull got %b want 0", req_valid); end
    tick();
  endtask

  task automatic test_flush_branch();
    bit ep;
    drain();
    ep = m_epoch;
    drive(1, 32'h1004, 1, 32'h2000, 0, 1, 0);
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL fb_redirect_valid got %b want 0", req_valid); end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({req_valid, req_addr} !== {1'b1, 32'h1000}) begin
      n_err++; $display("FAIL fb_req got v=%b a=%h want v=1 a=00001000", req_valid, req_addr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus_v, bus_epoch, bus_mask, bus_pc} !== {1'b1, !ep, 2'b10, 32'h1004}) begin
      n_err++; $display("FAIL fb_bus got %h want v=1 e=%b m=10 pc=00001004", bus, !ep);
    end
    tick();
  endtask

  task automatic test_stall_branch();
    drain();
    drive(0, 0, 1, 32'h3000, 1, 0, 0);
    n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL sb_valid got %b want 0", req_valid); end
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    n_cmp++;
    if ({req_valid, req_addr} !== {1'b0, 32'h3000}) begin
      n_err++; $display("FAIL sb_stalled got v=%b a=%h want v=0 a=00003000", req_valid, req_addr);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({req_valid, req_addr} !== {1'b1, 32'h3000}) begin
      n_err++; $display("FAIL sb_release got v=%b a=%h want v=1 a=00003000", req_valid, req_addr);
    end
    tick();
  endtask

  task automatic test_wrap();
    drain();
    drive(1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({req_valid, req_addr} !== {1'b1, 32'hFFFF_FFF8}) begin
      n_err++; $display("FAIL wrap_first got v=%b a=%h want v=1 a=fffffff8", req_valid, req_addr);
    end
    tick();
    // Flush while the fired block sits on the IF2 bus: block must be killed.
    drive(1, 32'h7000, 0, 0, 0, 1, 1);
    n_cmp++; if (req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 00000000", req_addr); end
    n_cmp++; if (bus_v !== 1'b0) begin n_err++; $display("FAIL flush_kills_bus got %b want 0", bus_v); end
    tick();
  endtask

`ifdef IF_PCGEN_ALIGN_CHK_EN
  task automatic test_misalign();
    drain();
    drive(1, 32'h1002, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({misalign, req_valid} !== 2'b10) begin
      n_err++; $display("FAIL mis_pulse got mis=%b v=%b want mis=1 v=0", misalign, req_valid);
    end
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({misalign, req_valid} !== 2'b00) begin
      n_err++; $display("FAIL mis_hold got mis=%b v=%b want mis=0 v=0", misalign, req_valid);
    end
    tick();
    drive(1, 32'h1000, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({req_valid, req_addr} !== {1'b1, 32'h1000}) begin
      n_err++; $display("FAIL mis_recover got v=%b a=%h want v=1 a=00001000", req_valid, req_addr);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    logic [31:0] npc, ba;
    bit f, be, st, rdy, rsp;
    for (int c = 0; c < 400; c++) begin
      f   = ($urandom_range(15) == 0);
      be  = ($urandom_range(11) == 0);
      st  = ($urandom_range(3) == 0);
      rdy = ($urandom_range(2) != 0);
      rsp = ($urandom_range(1) == 0);
      npc = $urandom;
      ba  = $urandom;
      if ($urandom_range(3) != 0) begin npc[1:0] = 2'b00; ba[1:0] = 2'b00; end
      drive(f, npc, be, ba, st, rdy, rsp);
      n_cmp++;
      if (req_valid !== exp_req_valid()) begin
        n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", c, req_valid, exp_req_valid());
      end
      if (exp_req_valid()) begin
        n_cmp++;
        if (req_addr !== exp_addr()) begin
          n_err++; $display("FAIL rnd_addr[%0d] got %h want %h", c, req_addr, exp_addr());
        end
      end
      n_cmp++;
      if (bus_v !== (m_bv && !f)) begin
        n_err++; $display("FAIL rnd_bus_v[%0d] got %b want %b", c, bus_v, m_bv && !f);
      end
      if (m_bv && !f) begin
        n_cmp++;
        if ({bus_epoch, bus_mask, bus_pc} !== {m_be, m_bm, m_bp}) begin
          n_err++; $display("FAIL rnd_bus[%0d] got e=%b m=%b pc=%h want e=%b m=%b pc=%h",
                            c, bus_epoch, bus_mask, bus_pc, m_be, m_bm, m_bp);
        end
      end
`ifdef IF_PCGEN_ALIGN_CHK_EN
      n_cmp++;
      if (misalign !== m_mis) begin
        n_err++; $display("FAIL rnd_misalign[%0d] got %b want %b", c, misalign, m_mis);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_outst_limit();
    test_flush_branch();
    test_stall_branch();
    test_wrap();
`ifdef IF_PCGEN_ALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
